// File: rtl/peripheral_noc_router_lookup.sv
// Routing stage behind a NoC input FIFO: decodes each header's destination through a static
// table and forwards the whole packet to one output channel via a single registered stage.
module peripheral_noc_router_lookup #(
    parameter int FLIT_WIDTH = 32,
    parameter int DEST_WIDTH = 5,
    parameter int DESTS      = 32,
    parameter int OUTPUTS    = 5,
    parameter logic [DESTS*OUTPUTS-1:0] ROUTES = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [FLIT_WIDTH-1:0] in_flit,
    input  logic                  in_last,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [FLIT_WIDTH-1:0] out_flit,
    output logic                  out_last,
    output logic [OUTPUTS-1:0]    out_valid,
    input  logic [OUTPUTS-1:0]    out_ready,
    output logic                  drop_pulse
);

    // state | meaning
    // HEAD  | next accepted flit is a header, decoded through the table
    // BODY  | forwarding body flits on the latched route
    // DROP  | consuming and discarding an unroutable packet
    typedef enum logic [1:0] {HEAD, BODY, DROP} state_t;

    state_t                state;
    logic [OUTPUTS-1:0]    route_q;
    logic [OUTPUTS-1:0]    entry;
    logic [OUTPUTS-1:0]    head_route;
    logic [OUTPUTS-1:0]    sel;
    logic [DEST_WIDTH-1:0] dest;
    logic                  drain;
    logic                  accept;
    logic                  fwd;

    assign dest = in_flit[FLIT_WIDTH-1 -: DEST_WIDTH];

    // Destinations beyond the table fall through to the all-zero (unmapped) default.
    always_comb begin
        entry = '0;
        for (int d = 0; d < DESTS; d++) begin
            if (dest == DEST_WIDTH'(d)) begin
                entry = ROUTES[d*OUTPUTS +: OUTPUTS];
            end
        end
    end

    // Isolate the lowest set bit so a malformed multi-hot entry still selects one output.
    assign head_route = entry & (~entry + OUTPUTS'(1));

    assign drain    = |(out_valid & out_ready);
    assign in_ready = (state == DROP) | ~(|out_valid) | drain;
    assign accept   = in_valid & in_ready;
    assign sel      = (state == BODY) ? route_q : head_route;
    assign fwd      = (state == BODY) | ((state == HEAD) & (|head_route));

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= HEAD;
            route_q    <= '0;
            out_flit   <= '0;
            out_last   <= 1'b0;
            out_valid  <= '0;
            drop_pulse <= 1'b0;
        end else begin
            drop_pulse <= 1'b0;

            if (accept & fwd) begin
                out_flit  <= in_flit;
                out_last  <= in_last;
                out_valid <= sel;
            end else if (drain) begin
                out_valid <= '0;
            end

            if (accept) begin
                case (state)
                    HEAD: begin
                        if (|head_route) begin
                            if (!in_last) begin
                                route_q <= head_route;
                                state   <= BODY;
                            end
                        end else if (in_last) begin
                            drop_pulse <= 1'b1;
                        end else begin
                            state <= DROP;
                        end
                    end
                    BODY: begin
                        if (in_last) state <= HEAD;
                    end
                    DROP: begin
                        if (in_last) begin
                            drop_pulse <= 1'b1;
                            state      <= HEAD;
                        end
                    end
                    default: state <= HEAD;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_peripheral_noc_router_lookup.sv
// Directed bench for peripheral_noc_router_lookup: forwarding, back-to-back packets,
// backpressure, unmapped drops, drop behind a buffered flit and mid-packet reset.
module tb_peripheral_noc_router_lookup;

    localparam int FW = 32;
    localparam int DW = 5;
    localparam int ND = 32;
    localparam int NO = 5;
    // entry 3 -> output 2, entry 7 -> output 0, entry 12 multi-hot (01010) -> output 1
    localparam logic [ND*NO-1:0] RT = ((ND*NO)'(5'b00100) << (3*NO))
                                    | ((ND*NO)'(5'b00001) << (7*NO))
                                    | ((ND*NO)'(5'b01010) << (12*NO));

    logic          clk = 1'b0;
    logic          rst;
    logic [FW-1:0] in_flit;
    logic          in_last;
    logic          in_valid;
    logic          in_ready;
    logic [FW-1:0] out_flit;
    logic          out_last;
    logic [NO-1:0] out_valid;
    logic [NO-1:0] out_ready;
    logic          drop_pulse;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    peripheral_noc_router_lookup #(
        .FLIT_WIDTH(FW), .DEST_WIDTH(DW), .DESTS(ND), .OUTPUTS(NO), .ROUTES(RT)
    ) dut (
        .clk(clk), .rst(rst),
        .in_flit(in_flit), .in_last(in_last), .in_valid(in_valid), .in_ready(in_ready),
        .out_flit(out_flit), .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready),
        .drop_pulse(drop_pulse)
    );

    function automatic logic [FW-1:0] hdr(input logic [DW-1:0] d, input logic [FW-DW-1:0] p);
        return {d, p};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic drive(input logic [FW-1:0] f, input logic l, input logic v);
        in_flit  = f;
        in_last  = l;
        in_valid = v;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [FW-1:0] pkt [4];

        rst = 1'b1;
        out_ready = '1;
        drive('0, 1'b0, 1'b0);
        tick(); tick();
        rst = 1'b0;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_flit", 64'(out_flit), 64'(0));
        chk("rst_out_last", 64'(out_last), 64'(0));
        chk("rst_drop", 64'(drop_pulse), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(1));

        // 4-flit packet to dest 3 with downstream always ready
        pkt[0] = hdr(5'd3, 27'h100); pkt[1] = 32'h201; pkt[2] = 32'h202; pkt[3] = 32'h203;
        for (int i = 0; i < 4; i++) begin
            drive(pkt[i], i == 3, 1'b1);
            chk("fwd_in_ready", 64'(in_ready), 64'(1));
            tick();
            chk("fwd_valid", 64'(out_valid), 64'(5'b00100));
            chk("fwd_flit", 64'(out_flit), 64'(pkt[i]));
            chk("fwd_last", 64'(out_last), 64'(i == 3));
        end
        drive('0, 1'b0, 1'b0);
        tick();
        chk("fwd_idle", 64'(out_valid), 64'(0));

        // back-to-back single-flit packets to different outputs
        drive(hdr(5'd3, 27'h11), 1'b1, 1'b1);
        tick();
        chk("b2b_valid0", 64'(out_valid), 64'(5'b00100));
        drive(hdr(5'd7, 27'h22), 1'b1, 1'b1);
        chk("b2b_in_ready", 64'(in_ready), 64'(1));
        tick();
        chk("b2b_valid1", 64'(out_valid), 64'(5'b00001));
        chk("b2b_flit1", 64'(out_flit), 64'(hdr(5'd7, 27'h22)));

        // multi-hot table entry uses only its lowest set bit
        drive(hdr(5'd12, 27'h33), 1'b1, 1'b1);
        tick();
        chk("lowbit_valid", 64'(out_valid), 64'(5'b00010));
        drive('0, 1'b0, 1'b0);
        tick();
        chk("lowbit_idle", 64'(out_valid), 64'(0));

        // backpressure on output 2 for 5 cycles; other ready bits stay high
        pkt[0] = hdr(5'd3, 27'h300); pkt[1] = 32'h301; pkt[2] = 32'h302; pkt[3] = 32'h303;
        drive(pkt[0], 1'b0, 1'b1);
        tick();
        chk("bp_first", 64'(out_flit), 64'(pkt[0]));
        out_ready = 5'b11011;
        drive(pkt[1], 1'b0, 1'b1);
        chk("bp_in_ready_low", 64'(in_ready), 64'(0));
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("bp_hold_flit", 64'(out_flit), 64'(pkt[0]));
            chk("bp_hold_valid", 64'(out_valid), 64'(5'b00100));
            chk("bp_hold_ready", 64'(in_ready), 64'(0));
        end
        out_ready = '1;
        #1;
        chk("bp_resume_ready", 64'(in_ready), 64'(1));
        for (int i = 1; i < 4; i++) begin
            drive(pkt[i], i == 3, 1'b1);
            tick();
            chk("bp_order_flit", 64'(out_flit), 64'(pkt[i]));
            chk("bp_order_valid", 64'(out_valid), 64'(5'b00100));
            chk("bp_order_last", 64'(out_last), 64'(i == 3));
        end
        drive('0, 1'b0, 1'b0);
        tick();
        chk("bp_idle", 64'(out_valid), 64'(0));

        // unmapped destination, 3-flit packet is drained and dropped
        for (int i = 0; i < 3; i++) begin
            drive(i == 0 ? hdr(5'd9, 27'h400) : 32'h400 + 32'(i), i == 2, 1'b1);
            chk("drop_in_ready", 64'(in_ready), 64'(1));
            tick();
            chk("drop_no_valid", 64'(out_valid), 64'(0));
            chk("drop_pulse", 64'(drop_pulse), 64'(i == 2));
        end
        drive(hdr(5'd3, 27'h44), 1'b1, 1'b1);
        tick();
        chk("drop_pulse_once", 64'(drop_pulse), 64'(0));
        chk("after_drop_valid", 64'(out_valid), 64'(5'b00100));
        chk("after_drop_flit", 64'(out_flit), 64'(hdr(5'd3, 27'h44)));
        drive('0, 1'b0, 1'b0);
        tick();

        // unmapped packet arrives behind a stalled buffered flit
        out_ready = '0;
        drive(hdr(5'd3, 27'h55), 1'b1, 1'b1);
        tick();
        chk("dwb_buffered", 64'(out_valid), 64'(5'b00100));
        drive(hdr(5'd9, 27'h66), 1'b0, 1'b1);
        chk("dwb_blocked", 64'(in_ready), 64'(0));
        tick();
        chk("dwb_hold_flit", 64'(out_flit), 64'(hdr(5'd3, 27'h55)));
        chk("dwb_hold_valid", 64'(out_valid), 64'(5'b00100));
        out_ready = '1;
        #1;
        chk("dwb_ready", 64'(in_ready), 64'(1));
        tick();
        chk("dwb_delivered", 64'(out_valid), 64'(0));
        chk("dwb_flit_kept", 64'(out_flit), 64'(hdr(5'd3, 27'h55)));
        drive(32'h77, 1'b1, 1'b1);
        chk("dwb_drop_ready", 64'(in_ready), 64'(1));
        tick();
        chk("dwb_no_valid", 64'(out_valid), 64'(0));
        chk("dwb_pulse", 64'(drop_pulse), 64'(1));
        drive('0, 1'b0, 1'b0);
        tick();
        chk("dwb_pulse_end", 64'(drop_pulse), 64'(0));

        // reset after header + 1 body flit of a 4-flit packet
        drive(hdr(5'd3, 27'h1), 1'b0, 1'b1);
        tick();
        drive(32'h2, 1'b0, 1'b1);
        tick();
        chk("mid_body", 64'(out_flit), 64'(32'h2));
        rst = 1'b1;
        drive('0, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        chk("mrst_valid", 64'(out_valid), 64'(0));
        chk("mrst_drop", 64'(drop_pulse), 64'(0));
        chk("mrst_flit", 64'(out_flit), 64'(0));
        drive(hdr(5'd7, 27'h3), 1'b1, 1'b1);
        tick();
        chk("mrst_header_valid", 64'(out_valid), 64'(5'b00001));
        chk("mrst_header_flit", 64'(out_flit), 64'(hdr(5'd7, 27'h3)));
        drive('0, 1'b0, 1'b0);
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
